// File: rtl/bicubic_operand_feeder.sv
// Operand feeder for the bicubic core: fetches P(-1..2) from the image ROM and
// builds the Q0.8 power vector {1, x, x^2, x^3} with a single shared multiplier.
module bicubic_operand_feeder #(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int ADDR_W = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [$clog2(IMG_H)-1:0] req_row,
  input  logic [$clog2(IMG_W)-1:0] req_col,
  input  logic [7:0]               req_frac,
  output logic                     rom_rd,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [7:0]               rom_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               p0,
  output logic [7:0]               p1,
  output logic [7:0]               p2,
  output logic [7:0]               p3,
  output logic [7:0]               xp0,
  output logic [7:0]               xp1,
  output logic [7:0]               xp2,
  output logic [7:0]               xp3
);

  typedef enum logic [1:0] {IDLE, FETCH, OUT} state_t;

  state_t                   state;
  logic [2:0]               k_reg;
  logic [$clog2(IMG_H)-1:0] row_reg;
  logic [$clog2(IMG_W)-1:0] col_reg;
  logic [7:0]               mult_a;
  logic [15:0]              mult_p;

  // Column math is done in int so col-1 at the left border cannot wrap.
  function automatic logic [ADDR_W-1:0] addr_of(input logic [$clog2(IMG_H)-1:0] row,
                                                input logic [$clog2(IMG_W)-1:0] col,
                                                input int                       k);
    int c;
    c = int'(col) - 1 + k;
    if (c < 0)
      c = 0;
    else if (c > IMG_W - 1)
      c = IMG_W - 1;
    return ADDR_W'(int'(row) * IMG_W + c);
  endfunction

  // k=0 squares the fraction, k=1 multiplies the square by it again.
  always_comb begin
    mult_a = (k_reg == 3'd0) ? xp1 : xp2;
  end

  assign mult_p = ({8'd0, mult_a} * {8'd0, xp1}) + 16'd128;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k_reg     <= 3'd0;
      row_reg   <= '0;
      col_reg   <= '0;
      req_ready <= 1'b1;
      out_valid <= 1'b0;
      rom_rd    <= 1'b0;
      rom_addr  <= '0;
      p0        <= 8'd0;
      p1        <= 8'd0;
      p2        <= 8'd0;
      p3        <= 8'd0;
      xp0       <= 8'd0;
      xp1       <= 8'd0;
      xp2       <= 8'd0;
      xp3       <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            row_reg   <= req_row;
            col_reg   <= req_col;
            xp0       <= 8'hFF;
            xp1       <= req_frac;
            k_reg     <= 3'd0;
            req_ready <= 1'b0;
            rom_rd    <= 1'b1;
            rom_addr  <= addr_of(req_row, req_col, 0);
            state     <= FETCH;
          end
        end
        FETCH: begin
          case (k_reg)
            3'd0: xp2 <= mult_p[15:8];
            3'd1: begin
              xp3 <= mult_p[15:8];
              p0  <= rom_data;
            end
            3'd2: p1 <= rom_data;
            3'd3: p2 <= rom_data;
            default: p3 <= rom_data;
          endcase
          if (k_reg < 3'd3)
            rom_addr <= addr_of(row_reg, col_reg, int'(k_reg) + 1);
          else
            rom_rd <= 1'b0;
          if (k_reg == 3'd4) begin
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            k_reg <= k_reg + 3'd1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bicubic_operand_feeder.sv
// Directed bench for bicubic_operand_feeder with a ROM model and address/bundle
// scoreboards checked by a negedge monitor.
module tb_bicubic_operand_feeder;
  localparam int IMG_W  = 32;
  localparam int IMG_H  = 32;
  localparam int ADDR_W = 14;

  typedef struct packed {
    logic [7:0] p0, p1, p2, p3, x0, x1, x2, x3;
  } bun_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [4:0]        req_row;
  logic [4:0]        req_col;
  logic [7:0]        req_frac;
  logic              rom_rd;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        p0, p1, p2, p3, xp0, xp1, xp2, xp3;

  int total  = 0;
  int passed = 0;
  int failed = 0;
  int cyc    = 0;
  int acc_edge = 0;
  logic ov_prev = 1'b0;

  logic [ADDR_W-1:0] exp_addr[$];
  bun_t              exp_bun[$];
  int                hs_cyc[$];

  always #5 clk = ~clk;

  bicubic_operand_feeder #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_row(req_row), .req_col(req_col), .req_frac(req_frac),
    .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .p0(p0), .p1(p1), .p2(p2), .p3(p3),
    .xp0(xp0), .xp1(xp1), .xp2(xp2), .xp3(xp3)
  );

  function automatic logic [7:0] romf(input logic [ADDR_W-1:0] a);
    logic [31:0] t;
    t = 32'(a) * 37 + 11;
    return t[7:0];
  endfunction

  // Image ROM with one cycle of read latency.
  always @(posedge clk) begin
    if (rom_rd)
      rom_data <= romf(rom_addr);
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bun_t observed();
    return {p0, p1, p2, p3, xp0, xp1, xp2, xp3};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Latency: the accept edge counts as the first of six, so the rise is 5 edges later.
  always @(negedge clk) begin
    if (!rst) begin
      if (rom_rd) begin
        if (exp_addr.size() == 0)
          check("rom_rd_unexpected", 64'(rom_rd), 64'd0);
        else
          check("rom_addr", 64'(rom_addr), 64'(exp_addr.pop_front()));
      end
      if (out_valid && !ov_prev)
        check("latency", 64'(cyc - acc_edge), 64'd5);
      if (out_valid && out_ready) begin
        if (exp_bun.size() == 0)
          check("bundle_unexpected", 64'(out_valid), 64'd0);
        else
          check("bundle", observed(), exp_bun.pop_front());
        hs_cyc.push_back(cyc + 1);
      end
      if (req_valid && req_ready)
        acc_edge <= cyc + 1;
    end
    ov_prev <= out_valid;
  end

  function automatic logic [7:0] sq(input logic [7:0] a, input logic [7:0] b);
    int t;
    t = (int'(a) * int'(b) + 128) / 256;
    return t[7:0];
  endfunction

  function automatic logic [ADDR_W-1:0] ref_addr(input int row, input int col, input int k);
    int c;
    c = col - 1 + k;
    if (c < 0) c = 0;
    if (c > IMG_W - 1) c = IMG_W - 1;
    return ADDR_W'(row * IMG_W + c);
  endfunction

  task automatic do_req_exp(input int row, input int col, input logic [7:0] frac,
                            input int a0, input int a1, input int a2, input int a3,
                            input logic [7:0] x2, input logic [7:0] x3);
    bun_t b;
    bit   acc;
    int   n;
    exp_addr.push_back(ADDR_W'(a0));
    exp_addr.push_back(ADDR_W'(a1));
    exp_addr.push_back(ADDR_W'(a2));
    exp_addr.push_back(ADDR_W'(a3));
    b = '{romf(ADDR_W'(a0)), romf(ADDR_W'(a1)), romf(ADDR_W'(a2)), romf(ADDR_W'(a3)),
          8'hFF, frac, x2, x3};
    exp_bun.push_back(b);
    req_row   = 5'(row);
    req_col   = 5'(col);
    req_frac  = frac;
    req_valid = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      n++;
    end
    req_valid = 1'b0;
    if (!acc)
      check("req_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_req(input int row, input int col, input logic [7:0] frac);
    logic [7:0] x2;
    x2 = sq(frac, frac);
    do_req_exp(row, col, frac, int'(ref_addr(row, col, 0)), int'(ref_addr(row, col, 1)),
               int'(ref_addr(row, col, 2)), int'(ref_addr(row, col, 3)), x2, sq(x2, frac));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_bun.size() != 0 || exp_addr.size() != 0) && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_bun.size() != 0 || exp_addr.size() != 0)
      check("bundle_timeout", 64'(exp_bun.size()), 64'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_rom_rd"},    64'(rom_rd),    64'd0);
    check({tag, "_rom_addr"},  64'(rom_addr),  64'd0);
    check({tag, "_outputs"},   observed(),     64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bun_t held;
    int   n;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_row   = '0;
    req_col   = '0;
    req_frac  = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b0;

    do_req_exp(2, 5, 8'hC3, 68, 69, 70, 71, 8'h95, 8'h71);
    wait_idle();
    do_req_exp(2, 5, 8'h80, 68, 69, 70, 71, 8'h40, 8'h20);
    wait_idle();
    do_req_exp(2, 5, 8'h00, 68, 69, 70, 71, 8'h00, 8'h00);
    wait_idle();
    do_req_exp(2, 5, 8'hFF, 68, 69, 70, 71, 8'hFE, 8'hFD);
    wait_idle();

    do_req_exp(0, 0, 8'h40, 0, 0, 1, 2, 8'h10, 8'h04);
    wait_idle();
    do_req_exp(0, 31, 8'h40, 30, 31, 31, 31, 8'h10, 8'h04);
    wait_idle();
    do_req_exp(31, 31, 8'hC3, 1022, 1023, 1023, 1023, 8'h95, 8'h71);
    wait_idle();

    // Back-pressure: bundle must hold and stray requests must be ignored.
    out_ready = 1'b0;
    do_req(3, 10, 8'h5A);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    held = (exp_bun.size() != 0) ? exp_bun[0] : '0;
    check("bp_pending", 64'(exp_bun.size()), 64'd1);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_hold", observed(), held);
      check("bp_req_ready", 64'(req_ready), 64'd0);
      req_valid = 1'b1;
      req_row   = 5'd7;
      req_col   = 5'd20;
      req_frac  = 8'h11;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", 64'(out_valid), 64'd0);
    check("bp_release_req_ready", 64'(req_ready), 64'd1);
    check("bp_release_pending", 64'(exp_bun.size()), 64'd0);

    // Reset while the feeder is in FETCH with k=2.
    do_req(4, 12, 8'h33);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_addr.delete();
    exp_bun.delete();
    check_reset_state("midrst");
    @(posedge clk);
    #1;
    check("midrst_outputs_later", observed(), 64'd0);
    check("midrst_out_valid_later", 64'(out_valid), 64'd0);
    do_req(4, 12, 8'h33);
    wait_idle();

    hs_cyc.delete();
    do_req(5, 0, 8'h21);
    do_req(6, 31, 8'hE7);
    do_req(9, 17, 8'h9C);
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check("b2b_count", 64'(hs_cyc.size()), 64'd3);
    if (hs_cyc.size() == 3) begin
      check("b2b_spacing_1", 64'(hs_cyc[1] - hs_cyc[0]), 64'd7);
      check("b2b_spacing_2", 64'(hs_cyc[2] - hs_cyc[1]), 64'd7);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
